mnist_infer_ctrl: RTL
=====================

Name: mnist_infer_ctrl

Overview:
- Upstream sequencer for the MNIST MLP datapath.
- Accepts one 28x28 frame as a valid/ready byte stream and stores it in an internal pixel buffer.
- Drives the layer-1 pixel/address sweep, then the layer-2 hidden-feature sweep, then captures the argmax digit.
- Reports the result with a one-cycle valid pulse. One frame in flight; the next frame loads after the result.

Parameters:
- NUM_PIXELS, 784, pixels per frame; layer-1 address range 0..NUM_PIXELS-1.
- NUM_HIDDEN, 128, layer-1 neurons; layer-2 address range 0..NUM_HIDDEN-1.
- PIX_W, 8, pixel width.
- L1_LAT, 2, cycles from last layer-1 address until layer-1 outputs are stable.
- L2_LAT, 2, cycles from last layer-2 address until digit_in is stable.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- s_valid, in, 1, pixel stream valid.
- s_ready, out, 1, pixel stream ready.
- s_data, in, PIX_W, pixel byte.
- s_last, in, 1, marks the final pixel of a frame.
- pixel_out, out, PIX_W, pixel to layer 1.
- l1_addr, out, 10, layer-1 pixel index.
- l2_addr, out, 7, layer-2 feature index.
- l2_en, out, 1, layer-2 enable; low holds layer 2 in reset.
- acc_clr, out, 1, one-cycle layer-1 accumulator clear.
- acc_en, out, 1, layer accumulate enable; high only while an address is being consumed.
- digit_in, in, 4, argmax digit from the datapath.
- result_valid, out, 1, one-cycle result strobe.
- result_digit, out, 4, last classified digit.
- busy, out, 1, high in every state except LOAD.
- err_frame, out, 1, one-cycle frame-length error strobe.

Behaviour:
- Reset values (asynchronous): state=LOAD, s_ready=1, all counters 0, pixel_out=0, l1_addr=0, l2_addr=0, l2_en=0, acc_clr=0, acc_en=0, result_valid=0, result_digit=0, busy=0, err_frame=0.
- LOAD:
  - A beat transfers when s_valid && s_ready; it writes buf[wr_cnt] and increments wr_cnt.
  - Beat with s_last=1 at wr_cnt==NUM_PIXELS-1: frame accepted; go to CLEAR; s_ready drops the next cycle.
  - s_last=1 early, or wr_cnt==NUM_PIXELS-1 with s_last=0: err_frame pulses, wr_cnt returns to 0, frame is discarded, state stays in LOAD.
- CLEAR: acc_clr=1 for exactly one cycle; l2_en=0; go to L1_RUN.
- L1_RUN:
  - NUM_PIXELS cycles; cycle k drives l1_addr=k, pixel_out=buf[k], acc_en=1.
  - Buffer read is registered one cycle early, so pixel_out and l1_addr change on the same edge.
- L1_DRAIN: L1_LAT cycles; acc_en=0; l1_addr holds NUM_PIXELS-1.
- L2_RUN: NUM_HIDDEN cycles; l2_en=1; cycle j drives l2_addr=j, acc_en=1.
- L2_DRAIN: L2_LAT cycles; acc_en=0; l2_en stays 1; l2_addr holds NUM_HIDDEN-1.
- DONE (one cycle):
  - result_digit<=digit_in and result_valid=1.
  - Go to LOAD with wr_cnt=0.
  - l2_en stays 1 until the next CLEAR so the datapath result remains observable.
- Latency: last accepted beat to result_valid is 1+NUM_PIXELS+L1_LAT+NUM_HIDDEN+L2_LAT+1 cycles (918 at defaults).
- s_ready is 0 in every state except LOAD; s_valid there is ignored and never lost.
- result_digit holds its value until the next DONE.
- Reset mid-operation: immediate return to reset values; buffer contents are don't-care; a partial frame is abandoned.
- Counters are sized to their range; no wrap beyond NUM_PIXELS-1 / NUM_HIDDEN-1.

Optional Feature:
- MNIST_CYCLE_CNT_EN defined:
  - Adds output cycle_count[15:0], the number of cycles from CLEAR entry to DONE inclusive.
  - Loaded at DONE; reset value 0.
  - Saturates at 16'hFFFF.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package/include (config):
  - NUM_PIXELS, NUM_HIDDEN, PIX_W defaults.
  - State encoding localparams LOAD, CLEAR, L1_RUN, L1_DRAIN, L2_RUN, L2_DRAIN, DONE.
- One sub-module: mnist_pixel_buf, a NUM_PIXELS x PIX_W simple dual-port RAM (one write port, one registered read port) that infers block RAM.

Test Plan:
- Pixels 0..783 = (i mod 256), s_last on beat 783, digit_in=4'd7:
  - result_valid pulses exactly 918 cycles after the last beat; result_digit=7.
  - l1_addr sweeps 0..783 with pixel_out=l1_addr[7:0] each cycle.
  - l2_addr sweeps 0..127 with l2_en=1.
- s_last on beat 500:
  - err_frame pulses once and no CLEAR occurs.
  - A following full 784-beat frame completes normally.
- 784 beats with no s_last: err_frame on beat 784; s_ready stays 1.
- s_valid toggled 50% random during LOAD: the stored buffer matches the sent data, checked via the pixel_out sweep.
- rst pulsed in L2_RUN at l2_addr=60:
  - All outputs return to reset values; s_ready=1 the next cycle.
  - A new frame yields a correct result.
- Back-to-back frames with digit_in=3 then 9:
  - result_digit=3, then 9.
  - acc_clr pulses exactly once per frame.
  - s_ready=0 from CLEAR through DONE.

Source files
------------

// File: rtl/mnist_infer_ctrl_pkg.sv
// Shared configuration for the MNIST inference controller: default sizes,
// FSM state encoding and a small saturating-increment helper.
package mnist_infer_ctrl_pkg;

   localparam int NUM_PIXELS_DEF = 784;
   localparam int NUM_HIDDEN_DEF = 128;
   localparam int PIX_W_DEF      = 8;
   localparam int L1_LAT_DEF     = 2;
   localparam int L2_LAT_DEF     = 2;

   typedef enum logic [2:0] {
      LOAD     = 3'd0,
      CLEAR    = 3'd1,
      L1_RUN   = 3'd2,
      L1_DRAIN = 3'd3,
      L2_RUN   = 3'd4,
      L2_DRAIN = 3'd5,
      DONE     = 3'd6
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/mnist_pixel_buf.sv
// Frame pixel store: simple dual-port RAM, one write port and one registered
// read port, written without reset so it maps onto block RAM.
module mnist_pixel_buf
   import mnist_infer_ctrl_pkg::*;
#(
   parameter int DEPTH = NUM_PIXELS_DEF,
   parameter int W     = PIX_W_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/mnist_infer_ctrl.sv
// Upstream sequencer for the MNIST MLP: loads a frame, sweeps layer 1 and 2,
// captures the argmax digit. Optional cycle_count port via MNIST_CYCLE_CNT_EN.
module mnist_infer_ctrl
   import mnist_infer_ctrl_pkg::*;
#(
   parameter int NUM_PIXELS = NUM_PIXELS_DEF,
   parameter int NUM_HIDDEN = NUM_HIDDEN_DEF,
   parameter int PIX_W      = PIX_W_DEF,
   parameter int L1_LAT     = L1_LAT_DEF,
   parameter int L2_LAT     = L2_LAT_DEF,
   parameter int L1_AW      = $clog2(NUM_PIXELS),
   parameter int L2_AW      = $clog2(NUM_HIDDEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [PIX_W-1:0] s_data,
   input  logic             s_last,
   output logic [PIX_W-1:0] pixel_out,
   output logic [L1_AW-1:0] l1_addr,
   output logic [L2_AW-1:0] l2_addr,
   output logic             l2_en,
   output logic             acc_clr,
   output logic             acc_en,
   input  logic [3:0]       digit_in,
   output logic             result_valid,
   output logic [3:0]       result_digit,
   output logic             busy,
`ifdef MNIST_CYCLE_CNT_EN
   output logic [15:0]      cycle_count,
`endif
   output logic             err_frame
);

   localparam int LAT_MAX = (L1_LAT > L2_LAT) ? L1_LAT : L2_LAT;
   localparam int LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

   localparam logic [L1_AW-1:0] L1_LAST     = L1_AW'(NUM_PIXELS - 1);
   localparam logic [L2_AW-1:0] L2_LAST     = L2_AW'(NUM_HIDDEN - 1);
   localparam logic [LAT_W-1:0] L1_LAT_LAST = LAT_W'(L1_LAT - 1);
   localparam logic [LAT_W-1:0] L2_LAT_LAST = LAT_W'(L2_LAT - 1);

   state_t             state;
   state_t             state_next;
   logic [L1_AW-1:0]   wr_cnt;
   logic [LAT_W-1:0]   lat_cnt;
   logic               beat;
   logic               at_last;
   logic               frame_ok;
   logic               frame_err;
   logic               rd_en;
   logic [L1_AW-1:0]   rd_addr;
   logic [PIX_W-1:0]   rd_data;
   logic               pix_valid;

   // A frame is good only when s_last coincides with the final buffer slot.
   always_comb begin
      beat      = s_valid && (state == LOAD);
      at_last   = (wr_cnt == L1_LAST);
      frame_ok  = beat && s_last && at_last;
      frame_err = beat && (s_last != at_last);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOAD;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      busy       = 1'b1;
      acc_clr    = 1'b0;
      acc_en     = 1'b0;
      rd_en      = 1'b0;
      rd_addr    = l1_addr + 1'b1;
      case (state)
         LOAD: begin
            s_ready = 1'b1;
            busy    = 1'b0;
            if (frame_ok) begin
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            acc_clr    = 1'b1;
            rd_en      = 1'b1;
            rd_addr    = '0;
            state_next = L1_RUN;
         end
         L1_RUN: begin
            acc_en = 1'b1;
            if (l1_addr == L1_LAST) begin
               state_next = L1_DRAIN;
            end else begin
               rd_en = 1'b1;
            end
         end
         L1_DRAIN: begin
            if (lat_cnt == L1_LAT_LAST) begin
               state_next = L2_RUN;
            end
         end
         L2_RUN: begin
            acc_en = 1'b1;
            if (l2_addr == L2_LAST) begin
               state_next = L2_DRAIN;
            end
         end
         L2_DRAIN: begin
            if (lat_cnt == L2_LAT_LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = LOAD;
         end
         default: begin
            state_next = LOAD;
         end
      endcase
   end

   // Read runs one address ahead so the RAM output lines up with l1_addr.
   mnist_pixel_buf #(
      .DEPTH (NUM_PIXELS),
      .W     (PIX_W),
      .AW    (L1_AW)
   ) u_pixel_buf (
      .clk   (clk),
      .we    (beat),
      .waddr (wr_cnt),
      .wdata (s_data),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   assign pixel_out = pix_valid ? rd_data : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_cnt    <= '0;
         lat_cnt   <= '0;
         pix_valid <= 1'b0;
      end else begin
         if (beat) begin
            wr_cnt <= (frame_ok || frame_err) ? '0 : wr_cnt + 1'b1;
         end else if (state == DONE) begin
            wr_cnt <= '0;
         end
         if ((state == L1_DRAIN || state == L2_DRAIN) && state_next == state) begin
            lat_cnt <= lat_cnt + 1'b1;
         end else begin
            lat_cnt <= '0;
         end
         if (state == CLEAR) begin
            pix_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l1_addr <= '0;
         l2_addr <= '0;
         l2_en   <= 1'b0;
      end else begin
         if (state == L1_RUN && l1_addr != L1_LAST) begin
            l1_addr <= l1_addr + 1'b1;
         end else if (state == DONE) begin
            l1_addr <= '0;
         end
         if (state == CLEAR) begin
            l2_addr <= '0;
         end else if (state == L2_RUN && l2_addr != L2_LAST) begin
            l2_addr <= l2_addr + 1'b1;
         end
         // l2_en survives DONE so the datapath result stays visible in LOAD.
         if (state_next == CLEAR) begin
            l2_en <= 1'b0;
         end else if (state_next == L2_RUN) begin
            l2_en <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_valid <= 1'b0;
         result_digit <= 4'd0;
         err_frame    <= 1'b0;
      end else begin
         result_valid <= (state == DONE);
         err_frame    <= frame_err;
         if (state == DONE) begin
            result_digit <= digit_in;
         end
      end
   end

`ifdef MNIST_CYCLE_CNT_EN
   logic [15:0] run_cnt;

   // run_cnt reads 1 during CLEAR, so its value in DONE counts both ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt     <= 16'd0;
         cycle_count <= 16'd0;
      end else begin
         if (state == LOAD && state_next == CLEAR) begin
            run_cnt <= 16'd1;
         end else if (state != LOAD) begin
            run_cnt <= sat_inc16(run_cnt);
         end
         if (state == DONE) begin
            cycle_count <= run_cnt;
         end
      end
   end
`endif

endmodule
